// File: rtl/ram_pkg.sv
// Shared types and helpers for the ram_sdp_clr storage block.
// Holds the clear-engine state encoding and the even-parity helper.
package ram_pkg;

  // Two-state controller: CLEAR sweeps the array, IDLE serves user traffic
  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  // Widest word the parity helper accepts; callers zero-extend, which does
  // not change the parity of the value
  localparam int PARITY_MAX_WIDTH = 64;

  // Even-parity bit: makes the total count of ones (data + bit) even
  function automatic logic even_parity(input logic [PARITY_MAX_WIDTH-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/ram_sdp_core.sv
// Storage array for ram_sdp_clr: one write port, one registered read port.
// The array itself is never reset; only the read output register is.
// When PAR_EN=1 the top bit of each stored word is a parity bit that is
// checked on every read.
module ram_sdp_core #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int RAM_DEPTH  = 16,
  parameter int PAR_EN     = 0,
  parameter int STORE_W    = DATA_WIDTH + PAR_EN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [STORE_W-1:0]    wr_word,
  input  logic                  rd_en,
  input  logic                  rd_zero,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  par_err
);
  import ram_pkg::*;

  logic [STORE_W-1:0] mem [RAM_DEPTH];
  logic [STORE_W-1:0] rd_word;
  logic               rd_par_bad;

  assign rd_word = mem[rd_addr];

  generate
    if (PAR_EN != 0) begin : g_parity
      assign rd_par_bad = rd_word[STORE_W-1] !=
                          even_parity(PARITY_MAX_WIDTH'(rd_word[DATA_WIDTH-1:0]));
    end else begin : g_no_parity
      assign rd_par_bad = 1'b0;
    end
  endgenerate

  // Array write port; no reset so the array maps onto plain RAM cells
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_word;
    end
  end

  // Registered read: samples the old word, so a same-address write is read-first
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data <= '0;
      par_err <= 1'b0;
    end else if (rd_en) begin
      if (rd_zero) begin
        rd_data <= '0;
        par_err <= 1'b0;
      end else begin
        rd_data <= rd_word[DATA_WIDTH-1:0];
        par_err <= rd_par_bad;
      end
    end else begin
      par_err <= 1'b0;
    end
  end

endmodule

// File: rtl/ram_sdp_clr.sv
// Simple-dual-port synchronous RAM with a built-in clear engine.
// After reset, or on clr_req while idle, every word is overwritten with
// CLEAR_VALUE, one address per cycle; user accesses are ignored meanwhile.
// Optional feature macro: RAM_PARITY_EN adds a stored even-parity bit per
// word, with wr_par_flip for fault injection and par_err on reads.
module ram_sdp_clr #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    ADDR_WIDTH  = 4,
  parameter int                    RAM_DEPTH   = 16,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cs,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_par_flip,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  par_err,
  input  logic                  clr_req,
  output logic                  busy,
  output logic                  clr_done
);
  import ram_pkg::*;

`ifdef RAM_PARITY_EN
  localparam int PAR_EN = 1;
`else
  localparam int PAR_EN = 0;
`endif
  localparam int STORE_W = DATA_WIDTH + PAR_EN;

  state_t                state;
  logic [ADDR_WIDTH-1:0] clr_ptr;
  logic                  clr_last;

  logic                  wr_in_range;
  logic                  rd_in_range;
  logic                  user_wr;
  logic                  user_rd;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_wr_addr;
  logic [DATA_WIDTH-1:0] mem_wr_data;
  logic [STORE_W-1:0]    mem_wr_word;

  assign clr_last    = int'(clr_ptr) == RAM_DEPTH - 1;
  assign wr_in_range = int'(wr_addr) < RAM_DEPTH;
  assign rd_in_range = int'(rd_addr) < RAM_DEPTH;
  assign user_wr     = cs & we & ~busy & wr_in_range;
  assign user_rd     = cs & rd_en & ~busy;

  // Clear controller: sweeps clr_ptr across the array, then reports done
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= CLEAR;
      clr_ptr  <= '0;
      busy     <= 1'b1;
      clr_done <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      case (state)
        CLEAR: begin
          if (clr_last) begin
            state    <= IDLE;
            clr_ptr  <= '0;
            busy     <= 1'b0;
            clr_done <= 1'b1;
          end else begin
            clr_ptr <= clr_ptr + 1'b1;
          end
        end
        IDLE: begin
          if (clr_req) begin
            state   <= CLEAR;
            clr_ptr <= '0;
            busy    <= 1'b1;
          end
        end
        default: begin
          state   <= CLEAR;
          clr_ptr <= '0;
          busy    <= 1'b1;
        end
      endcase
    end
  end

  // Write-port mux: the clear engine owns the port whenever a sweep is running
  always_comb begin
    mem_we      = 1'b0;
    mem_wr_addr = wr_addr;
    mem_wr_data = wr_data;
    if (state == CLEAR) begin
      mem_we      = rst_n;
      mem_wr_addr = clr_ptr;
      mem_wr_data = CLEAR_VALUE;
    end else if (user_wr) begin
      mem_we = 1'b1;
    end
  end

`ifdef RAM_PARITY_EN
  logic mem_wr_par;

  // Parity for the stored word; the clear engine always writes good parity
  always_comb begin
    mem_wr_par = even_parity(PARITY_MAX_WIDTH'(wr_data)) ^ wr_par_flip;
    if (state == CLEAR) begin
      mem_wr_par = even_parity(PARITY_MAX_WIDTH'(CLEAR_VALUE));
    end
  end

  assign mem_wr_word = {mem_wr_par, mem_wr_data};
`else
  logic unused_par_flip;

  assign unused_par_flip = wr_par_flip;
  assign mem_wr_word     = mem_wr_data;
`endif

  // Read-valid strobe, aligned with the registered read data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= user_rd;
    end
  end

  ram_sdp_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .RAM_DEPTH  (RAM_DEPTH),
    .PAR_EN     (PAR_EN),
    .STORE_W    (STORE_W)
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (mem_we),
    .wr_addr (mem_wr_addr),
    .wr_word (mem_wr_word),
    .rd_en   (user_rd),
    .rd_zero (~rd_in_range),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .par_err (par_err)
  );

endmodule
